cast_stage_buf: RTL and testbench

CAST_STAGE_BUF -- requirements
Module: cast_stage_buf

---
 rtl/cast_stage_buf.sv | 96 +++++++++
 tb/tb_cast_stage_buf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cast_stage_buf.sv
// Two-entry skid buffer that applies a zext/sext/trunc cast to each operand on entry.
// in_ready depends only on local state, so there is no combinational path from out_ready.
module cast_stage_buf #(
  parameter string ParamOpCode    = "none",
  parameter int    ParamBitWidth  = 32,
  parameter int    ReturnBitWidth = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ParamBitWidth-1:0]  lhs,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ReturnBitWidth-1:0] ret,
  output logic [1:0]                count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [ReturnBitWidth-1:0] main_q, main_d;
  logic [ReturnBitWidth-1:0] skid_q, skid_d;
  logic [ReturnBitWidth-1:0] cast_val;
  logic                      push, pop;

  // The cast is fixed at elaboration; unknown opcodes store zero.
  if (ParamOpCode == "zext") begin : g_zext
    assign cast_val = ReturnBitWidth'(lhs);
  end else if (ParamOpCode == "sext") begin : g_sext
    assign cast_val = ReturnBitWidth'($signed(lhs));
  end else if (ParamOpCode == "trunc") begin : g_trunc
    assign cast_val = ReturnBitWidth'(lhs);
  end else begin : g_none
    assign cast_val = '0;
  end

  assign in_ready  = enable & ~reset & (state_q != FULL);
  assign out_valid = enable & (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ret       = main_q;
  assign count     = state_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = cast_val;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = cast_val;
        end else if (push && pop) begin
          main_d  = cast_val;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two data registers are cleared too, so stale entries never reappear.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (enable) begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_cast_stage_buf.sv
// Directed bench for cast_stage_buf: cast variants, backpressure, streaming, reset and stall.
module tb_cast_stage_buf;

  logic clk = 1'b0;
  logic reset, enable;

  // Shared stimulus for the cast-variant instances.
  logic        c_valid, c_ready;
  logic [7:0]  lhs8;
  logic [31:0] lhs32;
  logic        s_ir, s_ov, z_ir, z_ov, t_ir, t_ov, n_ir, n_ov;
  logic [31:0] s_ret, z_ret, n_ret;
  logic [7:0]  t_ret;
  logic [1:0]  s_cnt, z_cnt, t_cnt, n_cnt;

  // Main zext 8->8 instance used for the flow-control scenarios.
  logic       d_valid, d_ready, d_ir, d_ov;
  logic [7:0] d_lhs, d_ret;
  logic [1:0] d_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cast_stage_buf #(.ParamOpCode("sext"), .ParamBitWidth(8), .ReturnBitWidth(32)) u_sext (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(c_valid), .in_ready(s_ir),
    .lhs(lhs8), .out_valid(s_ov), .out_ready(c_ready), .ret(s_ret), .count(s_cnt));

  cast_stage_buf #(.ParamOpCode("zext"), .ParamBitWidth(8), .ReturnBitWidth(32)) u_zext (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(c_valid), .in_ready(z_ir),
    .lhs(lhs8), .out_valid(z_ov), .out_ready(c_ready), .ret(z_ret), .count(z_cnt));

  cast_stage_buf #(.ParamOpCode("trunc"), .ParamBitWidth(32), .ReturnBitWidth(8)) u_trunc (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(c_valid), .in_ready(t_ir),
    .lhs(lhs32), .out_valid(t_ov), .out_ready(c_ready), .ret(t_ret), .count(t_cnt));

  cast_stage_buf u_none (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(c_valid), .in_ready(n_ir),
    .lhs(lhs32), .out_valid(n_ov), .out_ready(c_ready), .ret(n_ret), .count(n_cnt));

  cast_stage_buf #(.ParamOpCode("zext"), .ParamBitWidth(8), .ReturnBitWidth(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(d_valid), .in_ready(d_ir),
    .lhs(d_lhs), .out_valid(d_ov), .out_ready(d_ready), .ret(d_ret), .count(d_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, away from sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    c_valid = 1'b0; c_ready = 1'b0; lhs8 = '0; lhs32 = '0;
    d_valid = 1'b0; d_ready = 1'b0; d_lhs = '0;
    tick(); tick();

    // Reset state, and in_ready held low while reset is asserted.
    check("rst_count", 32'(d_cnt), 32'd0);
    check("rst_out_valid", 32'(d_ov), 32'd0);
    check("rst_in_ready", 32'(d_ir), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(d_ir), 32'd1);

    // Cast variants, 1-cycle latency from EMPTY.
    c_valid = 1'b1; c_ready = 1'b1; lhs8 = 8'h80; lhs32 = 32'h1234_5678;
    tick();
    c_valid = 1'b0;
    check("sext_out_valid", 32'(s_ov), 32'd1);
    check("sext_ret", s_ret, 32'hFFFF_FF80);
    check("sext_count", 32'(s_cnt), 32'd1);
    check("zext_ret", z_ret, 32'h0000_0080);
    check("trunc_ret", 32'(t_ret), 32'h78);
    check("none_valid", 32'(n_ov), 32'd1);
    check("none_ret", n_ret, 32'd0);
    tick();
    check("sext_drained", 32'(s_cnt), 32'd0);

    // Backpressure: fill both entries, then drain in order.
    d_ready = 1'b0; d_valid = 1'b1; d_lhs = 8'h11;
    tick();
    d_lhs = 8'h22;
    tick();
    d_valid = 1'b0;
    #1;
    check("bp_count_full", 32'(d_cnt), 32'd2);
    check("bp_in_ready", 32'(d_ir), 32'd0);
    check("bp_ret_head", 32'(d_ret), 32'h11);
    tick();
    check("bp_hold_ret", 32'(d_ret), 32'h11);
    check("bp_hold_valid", 32'(d_ov), 32'd1);
    d_ready = 1'b1;
    #1;
    check("bp_pop1_ret", 32'(d_ret), 32'h11);
    tick();
    check("bp_count_one", 32'(d_cnt), 32'd1);
    check("bp_pop2_ret", 32'(d_ret), 32'h22);
    check("bp_pop2_valid", 32'(d_ov), 32'd1);
    tick();
    check("bp_count_empty", 32'(d_cnt), 32'd0);
    check("bp_empty_valid", 32'(d_ov), 32'd0);

    // Streaming: prime one entry, then push and pop every cycle for 16 items.
    d_valid = 1'b1; d_lhs = 8'h30;
    tick();
    check("stream_prime_count", 32'(d_cnt), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      d_lhs = 8'(8'h30 + i);
      #1;
      check("stream_valid", 32'(d_ov), 32'd1);
      check("stream_in_ready", 32'(d_ir), 32'd1);
      check("stream_order", 32'(d_ret), 32'(8'h30 + i - 1));
      tick();
      check("stream_count", 32'(d_cnt), 32'd1);
    end
    d_valid = 1'b0; d_ready = 1'b0;
    #1;
    check("stream_last", 32'(d_ret), 32'h40);

    // Stall in ONE for three cycles with both sides willing to transfer.
    enable = 1'b0; d_valid = 1'b1; d_lhs = 8'h55; d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(d_ir), 32'd0);
      check("stall_out_valid", 32'(d_ov), 32'd0);
      check("stall_count", 32'(d_cnt), 32'd1);
      tick();
    end
    enable = 1'b1; d_valid = 1'b0; d_ready = 1'b0;
    #1;
    check("resume_valid", 32'(d_ov), 32'd1);
    check("resume_ret", 32'(d_ret), 32'h40);
    check("resume_count", 32'(d_cnt), 32'd1);
    d_valid = 1'b1; d_ready = 1'b1;
    tick();
    check("resume_next_ret", 32'(d_ret), 32'h55);

    // Reset out of FULL discards both entries.
    d_ready = 1'b0; d_lhs = 8'h66;
    tick();
    check("full_count", 32'(d_cnt), 32'd2);
    d_valid = 1'b0; reset = 1'b1;
    tick();
    check("fullrst_count", 32'(d_cnt), 32'd0);
    check("fullrst_valid", 32'(d_ov), 32'd0);
    check("fullrst_in_ready", 32'(d_ir), 32'd0);
    reset = 1'b0;
    tick();
    check("fullrst_in_ready_back", 32'(d_ir), 32'd1);
    check("fullrst_count_hold", 32'(d_cnt), 32'd0);
    d_valid = 1'b1; d_lhs = 8'h77; d_ready = 1'b1;
    tick();
    d_valid = 1'b0;
    check("after_rst_ret", 32'(d_ret), 32'h77);
    check("after_rst_count", 32'(d_cnt), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
